psum_requant_buffer: RTL and testbench
======================================

Name: psum_requant_buffer

Overview:
- Sits directly downstream of the 3x3 PE core.
- Captures each PE output (feature_out) per output pixel.
- On non-final input-channel passes, stores it as a partial sum and replays it to the PE core's adder_feature input on the next pass.
- On the final pass, rounds, shifts and saturates the accumulated value to FEATURE_WIDTH and emits it through a small output FIFO with ready/valid handshake.

Parameters:
- FEATURE_WIDTH, 16 (`FEATURE_WIDTH): width of the quantized output feature.
- MAC_OUTPUT_WIDTH, 40 (`MAC_OUTPUT_WIDTH): width of PE partial sums, two's complement.
- PSUM_DEPTH, 1024: partial-sum buffer entries, i.e. maximum pixels per pass.
- ADDR_WIDTH, 10: log2(PSUM_DEPTH).
- OUT_FIFO_DEPTH, 4: output FIFO entries; power of two.
- SHIFT_WIDTH, 6: width of the requant shift amount.

Ports:
- DSP_clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- pass_start  in  1  one-cycle pulse; begins a channel pass; samples last_pass, pixel_num, shift.
- last_pass  in  1  current pass is the final input channel.
- pixel_num  in  ADDR_WIDTH+1  pixels in this pass, 1..PSUM_DEPTH.
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount for requant, 0..MAC_OUTPUT_WIDTH-1.
- relu_en  in  1  clamp negatives to 0; only honoured with the optional feature.
- mac_in  in  MAC_OUTPUT_WIDTH  PE feature_out.
- mac_valid  in  1  mac_in valid this cycle.
- adder_rd_en  in  1  request next replayed partial sum.
- adder_feature  out  MAC_OUTPUT_WIDTH  replayed partial sum, valid 1 cycle after adder_rd_en.
- adder_valid  out  1  adder_feature valid.
- q_out  out  FEATURE_WIDTH  quantized output (FIFO head).
- q_valid  out  1  FIFO not empty.
- q_ready  in  1  downstream accepts q_out.
- stall  out  1  FIFO count >= OUT_FIFO_DEPTH-2; upstream must halt mac_valid within 2 cycles.
- pass_done  out  1  one-cycle pulse after the pass's last write.
- ovf_err  out  1  sticky; set on write into a full FIFO or on mac_valid in IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pointers, counts and FIFO cleared. Partial-sum RAM contents are not reset.
- Reset asserted mid-pass aborts the pass immediately; nothing is emitted after reset release until a new pass_start.

FSM states: IDLE, ACCUM, FINAL, DONE.
- IDLE: pass_start with last_pass=0 goes to ACCUM; pass_start with last_pass=1 goes to FINAL. Configuration is latched on that edge; wr_ptr and rd_ptr are cleared.
- ACCUM: each mac_valid writes mac_in to ram[wr_ptr] and increments wr_ptr. Leaves when the write count reaches latched pixel_num.
- FINAL: each mac_valid pushes requant(mac_in) into the FIFO; nothing is written to RAM. Leaves when the count reaches pixel_num.
- On completion of ACCUM or FINAL: go to DONE.
- DONE: pass_done=1 for exactly one cycle, then IDLE.
- pass_start outside IDLE is ignored.

Partial-sum replay:
- adder_rd_en reads ram[rd_ptr] and increments rd_ptr.
- Output is registered, so adder_valid and adder_feature appear the next cycle.
- Allowed in ACCUM and FINAL.
- Same-address read and write in one cycle returns the old data (read-first).
- rd_ptr beyond pixel_num-1 wraps to 0.

Requant (one pipeline register, FIFO push one cycle after mac_valid):
- shift=0: v = mac_in.
- shift>0: v = (mac_in + 2^(shift-1)) >>> shift, computed with a 1-bit guard so the rounding add cannot overflow.
- Saturate v to [-2^(FEATURE_WIDTH-1), 2^(FEATURE_WIDTH-1)-1].

Output FIFO:
- Push and pop in the same cycle when full: the pop is honoured and the push is accepted.
- Push when full without a pop: data is dropped and ovf_err is set.
- q_out is stable while q_valid=1 and q_ready=0.

Optional Feature:
- Macro: PSUM_REQUANT_RELU_EN.
- Defined: after saturation, if relu_en=1 and v<0, v is replaced by 0. Adds no latency.
- Undefined: relu_en is ignored; signed saturated values pass through unchanged.

Test Plan:
- ACCUM then FINAL replay: pass_start (last_pass=0, pixel_num=4); mac_in=10,20,30,40 -> pass_done 1 cycle after the 4th write. Next pass with adder_rd_en x4 -> adder_feature=10,20,30,40, each 1 cycle after its request.
- Requant rounding: FINAL pass, shift=4, mac_in=24 -> q_out=2; mac_in=-24 -> q_out=-1; mac_in=23 -> q_out=1.
- Saturation: FINAL pass, FEATURE_WIDTH=16, shift=0, mac_in=40000 -> q_out=32767; mac_in=-40000 -> q_out=-32768.
- Backpressure: FINAL pass, pixel_num=8, q_ready=0 -> stall=1 when count=2; 4 items held, q_out stable. A 5th mac_valid -> ovf_err=1. q_ready=1 -> first 4 values drain in order.
- Reset mid-pass: rst asserted after 2 of 4 writes -> all outputs 0, FSM IDLE. A new pass with pixel_num=1 completes with pass_done after one write.
- ReLU, macro defined: relu_en=1, shift=0, mac_in=-5 -> q_out=0. Macro undefined -> q_out=-5.

Source files
------------

// File: rtl/psum_requant_buffer.sv
// Partial-sum buffer and requantizer behind the 3x3 PE core: stores/replays psums across channel
// passes, and on the last pass rounds/saturates into a small output FIFO. ReLU: PSUM_REQUANT_RELU_EN.
module psum_requant_buffer #(
    parameter int FEATURE_WIDTH    = 16,
    parameter int MAC_OUTPUT_WIDTH = 40,
    parameter int PSUM_DEPTH       = 1024,
    parameter int ADDR_WIDTH       = 10,
    parameter int OUT_FIFO_DEPTH   = 4,
    parameter int SHIFT_WIDTH      = 6
) (
    input  logic                        DSP_clk,
    input  logic                        rst,
    input  logic                        pass_start,
    input  logic                        last_pass,
    input  logic [ADDR_WIDTH:0]         pixel_num,
    input  logic [SHIFT_WIDTH-1:0]      shift,
    input  logic                        relu_en,
    input  logic [MAC_OUTPUT_WIDTH-1:0] mac_in,
    input  logic                        mac_valid,
    input  logic                        adder_rd_en,
    output logic [MAC_OUTPUT_WIDTH-1:0] adder_feature,
    output logic                        adder_valid,
    output logic [FEATURE_WIDTH-1:0]    q_out,
    output logic                        q_valid,
    input  logic                        q_ready,
    output logic                        stall,
    output logic                        pass_done,
    output logic                        ovf_err
);

    localparam int MW  = MAC_OUTPUT_WIDTH;
    localparam int FW  = FEATURE_WIDTH;
    localparam int FAW = $clog2(OUT_FIFO_DEPTH);

    localparam logic [ADDR_WIDTH:0]    CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0]  PTR_ONE   = 1;
    localparam logic [SHIFT_WIDTH-1:0] SH_ONE    = 1;
    localparam logic [FAW-1:0]         FPTR_ONE  = 1;
    localparam logic [FAW:0]           FCNT_ONE  = 1;
    localparam logic [FAW:0]           FULL_LVL  = (FAW+1)'(OUT_FIFO_DEPTH);
    localparam logic [FAW:0]           STALL_LVL = (FAW+1)'(OUT_FIFO_DEPTH - 2);
    localparam logic signed [MW:0]     QMAX = $signed({{(MW-FW+2){1'b0}}, {(FW-1){1'b1}}});
    localparam logic signed [MW:0]     QMIN = $signed({{(MW-FW+2){1'b1}}, {(FW-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH:0]        pix_q, cnt_q, cnt_inc, pix_last;
    logic [SHIFT_WIDTH-1:0]     shift_q, sh_m1;
    logic [ADDR_WIDTH-1:0]      rd_ptr_q;
    logic [MW-1:0]              adder_q;
    logic                       adder_valid_q;
    logic                       pipe_valid_q;
    logic [FW-1:0]              pipe_data_q;
    logic                       ovf_q;
    logic                       ram_we, req_push, idle_mac;
    logic [MW-1:0]              ram [PSUM_DEPTH];

    logic signed [MW:0]         ext, rnd, sum, shifted;
    logic [FW-1:0]              q_next;

    logic [FW-1:0]              fifo_mem [OUT_FIFO_DEPTH];
    logic [FAW-1:0]             fifo_wp_q, fifo_rp_q;
    logic [FAW:0]               fifo_cnt_q;
    logic                       fifo_push, fifo_pop, fifo_full, fifo_accept, fifo_drop;

    assign cnt_inc  = cnt_q + CNT_ONE;
    assign pix_last = pix_q - CNT_ONE;

    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        req_push = 1'b0;
        idle_mac = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_mac = mac_valid;
                if (pass_start) state_d = last_pass ? FINAL : ACCUM;
            end
            ACCUM: begin
                ram_we = mac_valid;
                if (mac_valid && cnt_inc == pix_q) state_d = DONE;
            end
            FINAL: begin
                req_push = mac_valid;
                if (mac_valid && cnt_inc == pix_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round half up with a guard bit, then arithmetic shift and saturate.
    always_comb begin
        sh_m1 = shift_q - SH_ONE;
        rnd   = '0;
        if (shift_q != '0) rnd[sh_m1] = 1'b1;
        ext     = {mac_in[MW-1], mac_in};
        sum     = ext + rnd;
        shifted = sum >>> shift_q;
        if (shifted > QMAX)      q_next = QMAX[FW-1:0];
        else if (shifted < QMIN) q_next = QMIN[FW-1:0];
        else                     q_next = shifted[FW-1:0];
`ifdef PSUM_REQUANT_RELU_EN
        if (relu_en && q_next[FW-1]) q_next = '0;
`endif
    end

`ifndef PSUM_REQUANT_RELU_EN
    logic unused_relu;
    assign unused_relu = relu_en;
`endif

    // RAM is not reset; read-first falls out of the non-blocking write.
    always_ff @(posedge DSP_clk) begin
        if (ram_we) ram[cnt_q[ADDR_WIDTH-1:0]] <= mac_in;
    end

    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            pix_q         <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            rd_ptr_q      <= '0;
            adder_q       <= '0;
            adder_valid_q <= 1'b0;
            pipe_valid_q  <= 1'b0;
            pipe_data_q   <= '0;
            ovf_q         <= 1'b0;
        end else begin
            if (state_q == IDLE && pass_start) begin
                pix_q    <= pixel_num;
                shift_q  <= shift;
                cnt_q    <= '0;
                rd_ptr_q <= '0;
            end else if (ram_we || req_push) begin
                cnt_q <= cnt_inc;
            end
            adder_valid_q <= 1'b0;
            if (adder_rd_en && (state_q == ACCUM || state_q == FINAL)) begin
                adder_q       <= ram[rd_ptr_q];
                adder_valid_q <= 1'b1;
                if ({1'b0, rd_ptr_q} == pix_last) rd_ptr_q <= '0;
                else                              rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            pipe_valid_q <= req_push;
            if (req_push) pipe_data_q <= q_next;
            if (idle_mac || fifo_drop) ovf_q <= 1'b1;
        end
    end

    assign fifo_push   = pipe_valid_q;
    assign fifo_pop    = q_valid && q_ready;
    assign fifo_full   = fifo_cnt_q == FULL_LVL;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign fifo_accept = fifo_push && (!fifo_full || fifo_pop);
    assign fifo_drop   = fifo_push && fifo_full && !fifo_pop;

    always_ff @(posedge DSP_clk) begin
        if (fifo_accept) fifo_mem[fifo_wp_q] <= pipe_data_q;
    end

    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_accept) fifo_wp_q <= fifo_wp_q + FPTR_ONE;
            if (fifo_pop)    fifo_rp_q <= fifo_rp_q + FPTR_ONE;
            if (fifo_accept && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + FCNT_ONE;
            else if (!fifo_accept && fifo_pop) fifo_cnt_q <= fifo_cnt_q - FCNT_ONE;
        end
    end

    assign q_valid       = fifo_cnt_q != '0;
    assign q_out         = q_valid ? fifo_mem[fifo_rp_q] : '0;
    assign stall         = fifo_cnt_q >= STALL_LVL;
    assign pass_done     = state_q == DONE;
    assign ovf_err       = ovf_q;
    assign adder_feature = adder_q;
    assign adder_valid   = adder_valid_q;

endmodule

// File: tb/tb_psum_requant_buffer.sv
// Directed-plus-random bench for psum_requant_buffer; expected values come from an arithmetic model.
module tb_psum_requant_buffer;

    localparam int FW = 16;
    localparam int MW = 40;
    localparam int AW = 10;
    localparam int SW = 6;

    logic          DSP_clk = 1'b0;
    logic          rst = 1'b1;
    logic          pass_start = 1'b0;
    logic          last_pass = 1'b0;
    logic [AW:0]   pixel_num = '0;
    logic [SW-1:0] shift = '0;
    logic          relu_en = 1'b0;
    logic [MW-1:0] mac_in = '0;
    logic          mac_valid = 1'b0;
    logic          adder_rd_en = 1'b0;
    logic [MW-1:0] adder_feature;
    logic          adder_valid;
    logic [FW-1:0] q_out;
    logic          q_valid;
    logic          q_ready = 1'b1;
    logic          stall;
    logic          pass_done;
    logic          ovf_err;

    psum_requant_buffer dut (
        .DSP_clk      (DSP_clk),
        .rst          (rst),
        .pass_start   (pass_start),
        .last_pass    (last_pass),
        .pixel_num    (pixel_num),
        .shift        (shift),
        .relu_en      (relu_en),
        .mac_in       (mac_in),
        .mac_valid    (mac_valid),
        .adder_rd_en  (adder_rd_en),
        .adder_feature(adder_feature),
        .adder_valid  (adder_valid),
        .q_out        (q_out),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .stall        (stall),
        .pass_done    (pass_done),
        .ovf_err      (ovf_err)
    );

    always #5 DSP_clk = ~DSP_clk;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [FW-1:0] exp_q[$];
    logic [MW-1:0] a_vals[6];
    logic [MW-1:0] b_vals[6];
    logic [MW-1:0] m;
    int            rd_exp[5] = '{10, 20, 30, 40, 10};
    int            rq_in[4] = '{24, -24, 23, 8};
    int            rq_exp[4] = '{2, -1, 1, 1};
    int            sh;
    int            v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scores the FIFO head whenever it will be consumed at the coming edge.
    task automatic tick();
        if (q_valid && q_ready) begin
            if (exp_q.size() == 0) check("q_valid_unexpected", 64'(q_valid), 64'(0));
            else check("q_out_stream", 64'(q_out), 64'(exp_q.pop_front()));
        end
        @(posedge DSP_clk);
        #1;
    endtask

    task automatic start_pass(input bit lp, input int pn, input int s);
        pass_start = 1'b1;
        last_pass  = lp;
        pixel_num  = (AW+1)'(pn);
        shift      = SW'(s);
        tick();
        pass_start = 1'b0;
    endtask

    function automatic logic [MW-1:0] rand40();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[MW-1:0];
    endfunction

    function automatic logic [MW-1:0] rand_small();
        logic signed [MW-1:0] s;
        s = rand40();
        return s >>> $urandom_range(30, 0);
    endfunction

    // Round-half-up divide by 2^s, then clamp to the signed output range.
    function automatic logic [FW-1:0] ref_q(input logic [MW-1:0] mv, input int s, input bit relu);
        longint x;
        longint r;
        x = longint'($signed(mv));
        if (s == 0) r = x;
        else r = (x + (longint'(1) <<< (s - 1))) >>> s;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef PSUM_REQUANT_RELU_EN
        if (relu && r < 0) r = 0;
`else
        if (relu) r = r;
`endif
        return FW'(r);
    endfunction

    task automatic drain(input string tag);
        mac_valid   = 1'b0;
        adder_rd_en = 1'b0;
        repeat (4) tick();
        check(tag, 64'(exp_q.size()), 64'(0));
        check({tag, "_qvalid"}, 64'(q_valid), 64'(0));
    endtask

    initial begin
        #3;
        check("rst_q_out", 64'(q_out), 64'(0));
        check("rst_q_valid", 64'(q_valid), 64'(0));
        check("rst_adder_valid", 64'(adder_valid), 64'(0));
        check("rst_adder_feature", 64'(adder_feature), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_pass_done", 64'(pass_done), 64'(0));
        check("rst_ovf", 64'(ovf_err), 64'(0));
        @(negedge DSP_clk);
        rst = 1'b0;
        tick();

        // Accumulate pass 10..40, then replay on the final pass with wrap.
        start_pass(0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            mac_valid = 1'b1;
            mac_in = MW'(10 * (i + 1));
            tick();
        end
        mac_valid = 1'b0;
        check("accum_pass_done", 64'(pass_done), 64'(1));
        tick();
        check("accum_pass_done_clear", 64'(pass_done), 64'(0));

        start_pass(1, 4, 4);
        for (int i = 0; i < 5; i++) begin
            adder_rd_en = 1'b1;
            tick();
            check("replay_valid", 64'(adder_valid), 64'(1));
            check("replay_data", 64'(adder_feature), 64'(MW'(rd_exp[i])));
        end
        adder_rd_en = 1'b0;
        tick();
        check("replay_valid_idle", 64'(adder_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            mac_valid = 1'b1;
            mac_in = MW'(rq_in[i]);
            exp_q.push_back(FW'(rq_exp[i]));
            tick();
        end
        check("final_pass_done", 64'(pass_done), 64'(1));
        drain("round_drain");

        // Saturation both ways, then ReLU on a small negative.
        start_pass(1, 3, 0);
        mac_valid = 1'b1;
        mac_in = MW'(40000);
        exp_q.push_back(16'h7fff);
        tick();
        mac_in = MW'(-40000);
        exp_q.push_back(16'h8000);
        tick();
        relu_en = 1'b1;
        mac_in = MW'(-5);
`ifdef PSUM_REQUANT_RELU_EN
        exp_q.push_back(16'h0000);
`else
        exp_q.push_back(16'hfffb);
`endif
        tick();
        relu_en = 1'b0;
        drain("sat_drain");

        // Backpressure: 5 items into a 4-deep FIFO with the sink stalled.
        q_ready = 1'b0;
        start_pass(1, 8, 0);
        for (int i = 0; i < 5; i++) begin
            v = int'($urandom_range(60000, 0)) - 30000;
            mac_valid = 1'b1;
            mac_in = MW'(v);
            if (i < 4) exp_q.push_back(ref_q(mac_in, 0, 1'b0));
            tick();
            if (i == 1) check("stall_low", 64'(stall), 64'(0));
            if (i == 2) check("stall_high", 64'(stall), 64'(1));
        end
        check("ovf_before_drop", 64'(ovf_err), 64'(0));
        check("held_q_out", 64'(q_out), 64'(exp_q[0]));
        mac_valid = 1'b0;
        tick();
        check("ovf_on_drop", 64'(ovf_err), 64'(1));
        check("held_q_out_stable", 64'(q_out), 64'(exp_q[0]));
        check("held_q_valid", 64'(q_valid), 64'(1));
        q_ready = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            mac_valid = 1'b1;
            mac_in = rand_small();
            exp_q.push_back(ref_q(mac_in, 0, 1'b0));
            tick();
        end
        check("bp_pass_done", 64'(pass_done), 64'(1));
        drain("bp_drain");

        // Random accumulate flow with read-first replay, then final requant.
        start_pass(0, 6, 0);
        for (int i = 0; i < 6; i++) begin
            a_vals[i] = rand40();
            mac_valid = 1'b1;
            mac_in = a_vals[i];
            tick();
        end
        mac_valid = 1'b0;
        tick();
        start_pass(0, 6, 0);
        for (int i = 0; i < 6; i++) begin
            b_vals[i] = rand40();
            mac_valid = 1'b1;
            adder_rd_en = 1'b1;
            mac_in = b_vals[i];
            tick();
            check("rand_replay_old", 64'(adder_feature), 64'(a_vals[i]));
        end
        mac_valid = 1'b0;
        adder_rd_en = 1'b0;
        check("rand_accum_done", 64'(pass_done), 64'(1));
        tick();
        sh = int'($urandom_range(24, 1));
        start_pass(1, 6, sh);
        for (int i = 0; i < 6; i++) begin
            m = rand_small();
            mac_valid = 1'b1;
            adder_rd_en = 1'b1;
            mac_in = m;
            exp_q.push_back(ref_q(m, sh, 1'b0));
            tick();
            check("rand_replay_new", 64'(adder_feature), 64'(b_vals[i]));
        end
        check("rand_final_done", 64'(pass_done), 64'(1));
        drain("rand_drain");

        // Reset in the middle of a final pass.
        start_pass(1, 4, 0);
        for (int i = 0; i < 2; i++) begin
            mac_valid = 1'b1;
            mac_in = MW'(100 + i);
            exp_q.push_back(FW'(100 + i));
            tick();
        end
        rst = 1'b1;
        #2;
        exp_q.delete();
        mac_valid = 1'b0;
        check("midrst_q_valid", 64'(q_valid), 64'(0));
        check("midrst_q_out", 64'(q_out), 64'(0));
        check("midrst_stall", 64'(stall), 64'(0));
        check("midrst_ovf", 64'(ovf_err), 64'(0));
        check("midrst_adder_valid", 64'(adder_valid), 64'(0));
        #4;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_q_valid", 64'(q_valid), 64'(0));
            check("post_rst_pass_done", 64'(pass_done), 64'(0));
        end
        start_pass(0, 1, 0);
        mac_valid = 1'b1;
        mac_in = MW'(1234);
        tick();
        mac_valid = 1'b0;
        check("single_pass_done", 64'(pass_done), 64'(1));
        tick();

        // A beat while idle is an error.
        check("ovf_idle_before", 64'(ovf_err), 64'(0));
        mac_valid = 1'b1;
        tick();
        mac_valid = 1'b0;
        check("ovf_idle", 64'(ovf_err), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
